// File: rtl/serial_pkg.sv
// Shared serial-stream constants: FSM encoding and default geometry used by the
// pattern transmitter and the detector benches.
package serial_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = 4;
  localparam int GAP_DEF   = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/pattern_shifter.sv
// Parallel-load MSB-first shift register with a down-counting bit index.
// Load and shift take effect on the next edge; no backpressure, load wins over shift.
module pattern_shifter
  import serial_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_dat,
  output logic             msb,
  output logic             last
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] sh;
  logic [CW-1:0]    cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh  <= '0;
      cnt <= '0;
    end else if (load) begin
      sh  <= load_dat;
      cnt <= CW'(WIDTH - 1);
    end else if (shift) begin
      sh  <= {sh[WIDTH-2:0], 1'b0};
      cnt <= cnt - CW'(1);
    end
  end

  assign msb  = sh[WIDTH-1];
  assign last = (cnt == '0);

endmodule

// File: rtl/serial_pattern_tx.sv
// Serializes a captured pattern MSB-first, R times with GAP idle cycles between repeats.
// First bit one cycle after accepted start, done one cycle after last bit; no backpressure.
module serial_pattern_tx
  import serial_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int GAP   = GAP_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_n,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int GW = (GAP < 1) ? 1 : $clog2(GAP + 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] pat_q;
  logic [CNT_W-1:0] rep_cnt;
  logic [GW-1:0]    gap_cnt;
  logic [WIDTH-1:0] load_dat;
  logic             load;
  logic             shift;
  logic             msb;
  logic             last;
  logic             more;

  // rep_cnt still counts the repeat in flight, so "more" means another one follows.
  assign more = (rep_cnt > CNT_W'(1));

  always_comb begin
    load     = 1'b0;
    shift    = 1'b0;
    load_dat = pat_q;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load     = 1'b1;
          load_dat = pattern;
        end
      end
      ST_SHIFT: begin
        if (!last)                 shift = 1'b1;
        else if (more && GAP == 0) load  = 1'b1;
      end
      ST_GAP: begin
        if (gap_cnt == '0) load = 1'b1;
      end
      default: ;
    endcase
  end

  pattern_shifter #(.WIDTH(WIDTH)) u_shifter (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .shift    (shift),
    .load_dat (load_dat),
    .msb      (msb),
    .last     (last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      pat_q   <= '0;
      rep_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            pat_q   <= pattern;
            rep_cnt <= (repeat_n == '0) ? CNT_W'(1) : repeat_n;
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (last) begin
            rep_cnt <= rep_cnt - CNT_W'(1);
            if (!more) begin
              state <= ST_DONE;
            end else if (GAP != 0) begin
              state   <= ST_GAP;
              gap_cnt <= GW'(GAP - 1);
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == '0) state   <= ST_SHIFT;
          else               gap_cnt <= gap_cnt - GW'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Outputs decode state flops only, never the inputs.
  assign out_valid = (state == ST_SHIFT);
  assign busy      = (state == ST_SHIFT) || (state == ST_GAP);
  assign done      = (state == ST_DONE);
  assign out       = out_valid & msb;

endmodule

// File: doc/serial_pattern_tx.md
Name: serial_pattern_tx

Overview:
- Transmit-side companion to the serial bit-stream detectors.
- Latches a WIDTH-bit pattern on a start request and serializes it MSB-first, one bit per clock, repeated a programmable number of times.
- Inserts a fixed idle gap between repeats.
- Drives bench and loopback stimulus for the bit-sequence detectors and any downstream serial consumer.

Parameters:
- WIDTH, 8, pattern length in bits; must be 2 or greater.
- CNT_W, 4, width of the repeat-count input.
- GAP, 2, idle cycles inserted between consecutive repeats; 0 allowed, meaning back-to-back repeats.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset; rst=0 forces the reset state immediately.
- start  input  1  transmit request; sampled only in IDLE.
- pattern  input  WIDTH  bit pattern; captured on the accepted start cycle.
- repeat_n  input  CNT_W  number of transmissions; captured with pattern; 0 is treated as 1.
- out  output  1  serial data bit; 0 whenever out_valid=0.
- out_valid  output  1  high on every cycle that out carries a pattern bit.
- busy  output  1  high from the cycle after start is accepted through the last bit or gap cycle.
- done  output  1  single-cycle pulse after the final bit of the final repeat.

Behaviour:
- Reset, asynchronous while rst=0:
  - state=IDLE; shift register, bit counter, repeat counter and gap counter = 0.
  - out=0, out_valid=0, busy=0, done=0.
- All outputs are registered; none depends combinationally on inputs.
- States: IDLE, SHIFT, GAP, DONE.
- IDLE:
  - start=1 at edge k: capture pattern into shift register; capture repeat_n into the repeat counter (0 loads 1); bit counter=WIDTH-1; go to SHIFT.
  - In cycle k+1: out=pattern[WIDTH-1], out_valid=1, busy=1.
  - start=0: stay in IDLE.
- SHIFT:
  - Each edge shifts left by one and decrements the bit counter; out always shows the current MSB.
  - Exactly WIDTH consecutive out_valid cycles per repeat.
- End of a repeat (bit counter=0 at an edge): decrement the repeat counter.
  - Remaining repeats > 0 and GAP > 0: go to GAP for exactly GAP cycles with out=0, out_valid=0, busy=1; then reload the shift register from the captured copy and return to SHIFT.
  - Remaining repeats > 0 and GAP = 0: reload and continue SHIFT with no bubble; out_valid stays high.
  - Remaining repeats = 0: go to DONE.
- DONE: one cycle with done=1, busy=0, out_valid=0; then IDLE.
- A start in DONE is ignored.
- start while busy is ignored. pattern and repeat_n changes after capture have no effect.
- Latency: first bit appears 1 cycle after the accepted start. done occurs 1 cycle after the last bit.
- Total cycles from accepted start to done: R·WIDTH + (R−1)·GAP + 1, where R = max(repeat_n, 1).
- Reset mid-operation: immediate return to IDLE with all outputs 0. No done pulse. Next start begins a fresh transfer.
- Counters:
  - Bit counter is clog2(WIDTH) wide.
  - Gap counter is clog2(GAP+1) wide, minimum 1 bit.
  - repeat_n = 2^CNT_W−1 must run the full count without wrap.

Decomposition:
- Shared package serial_pkg:
  - state encoding localparams ST_IDLE, ST_SHIFT, ST_GAP, ST_DONE.
  - default WIDTH, CNT_W and GAP constants, reused by the detector benches.
- One natural sub-module: pattern_shifter.
  - Parallel-load, MSB-first shift register with bit counter.
  - Ports: load, shift, last flag.
- The FSM, repeat counter and gap counter stay in serial_pattern_tx.

Test Plan:
- Reset: hold rst=0 mid-transfer, then release → all outputs 0; start=1 with pattern=8'hA5 → bits 1,0,1,0,0,1,0,1 on cycles 1–8; done on cycle 9.
- Repeats: pattern=8'hE7, repeat_n=3, GAP=2 → 24 valid bits in groups of 8, separated by 2-cycle zero gaps; busy 28 cycles; done on cycle 29.
- Edge cases: repeat_n=0 behaves as 1, giving a single 8-bit burst. With GAP=0 and repeat_n=2, out_valid stays high for 16 consecutive cycles.
- Ignored inputs: start pulse during SHIFT and during DONE, and pattern changed mid-transfer → no restart; bits match the originally captured pattern.
- Loopback: out drives the 111 sequence_detector with pattern=8'b01110111, repeat_n=1 → detector out high on the cycles after the 3rd consecutive 1 of each run, at bit positions 3 and 7.
